// File: rtl/barrelshifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package barrelshifter_pkg;

    // Widest shift amount carried in a stage (covers D_SIZE up to 256).
    localparam int SHAMT_W = 8;

    // Canonical op encodings; 3'b011 folds onto ROR and 3'b111 onto ROL.
    typedef enum logic [2:0] {
        OP_SRL = 3'b000,
        OP_SRA = 3'b001,
        OP_ROR = 3'b010,
        OP_SLL = 3'b100,
        OP_ASL = 3'b101,
        OP_ROL = 3'b110
    } op_e;

    // Control carried alongside the data word in every pipeline stage.
    typedef struct packed {
        logic               valid;
        op_e                op;
        logic [SHAMT_W-1:0] shamt;
        logic               vf;
    } stage_t;

    // Fully decodes the 3-bit op field onto the six operations.
    function automatic op_e decode_op(input logic [2:0] code);
        op_e r;
        case (code)
            3'b000:         r = OP_SRL;
            3'b001:         r = OP_SRA;
            3'b010, 3'b011: r = OP_ROR;
            3'b100:         r = OP_SLL;
            3'b101:         r = OP_ASL;
            default:        r = OP_ROL;
        endcase
        return r;
    endfunction

    // Left ops run through the right-shifting layers on a bit-reversed word.
    function automatic logic is_left(input op_e op);
        return (op == OP_SLL) || (op == OP_ASL) || (op == OP_ROL);
    endfunction

    // Number of mux layers in stage j; earlier stages take the remainder.
    function automatic int layers_in_stage(input int nl, input int p, input int j);
        return nl / p + ((j < nl % p) ? 1 : 0);
    endfunction

    // Index of the first mux layer handled by stage j.
    function automatic int first_layer(input int nl, input int p, input int j);
        return j * (nl / p) + ((j < nl % p) ? j : nl % p);
    endfunction

endpackage

// File: rtl/barrelshifter_pipe_shift_layer.sv
// One combinational mux layer: right shift by 2^K when enabled.
// Works in the right-shift domain; left ops arrive bit-reversed, so ASL
// becomes "keep bit 0, shift the upper bits right with zero fill".
module shift_layer
    import barrelshifter_pkg::*;
#(
    parameter int D_SIZE = 32,
    parameter int K      = 0
) (
    input  logic [D_SIZE-1:0] data_i,
    input  op_e               op_i,
    input  logic              en_i,
    output logic [D_SIZE-1:0] data_o
);

    localparam int SH = 1 << K;

    logic [D_SIZE-1:0] shifted;

    // Per-bit source select with fill chosen by the op
    always_comb begin
        shifted = '0;
        for (int i = 0; i < D_SIZE; i++) begin
            if (i + SH < D_SIZE) begin
                shifted[i] = data_i[(i + SH) % D_SIZE];
            end else begin
                case (op_i)
                    OP_ROR, OP_ROL: shifted[i] = data_i[(i + SH) % D_SIZE];
                    OP_SRA:         shifted[i] = data_i[D_SIZE-1];
                    default:        shifted[i] = 1'b0;
                endcase
            end
        end
        // Reversed ASL: the original sign bit sits at bit 0 and never moves.
        if (op_i == OP_ASL) begin
            shifted[0] = data_i[0];
        end
    end

    assign data_o = en_i ? shifted : data_i;

endmodule

// File: rtl/barrelshifter_pipe.sv
// Pipelined, flow-controlled barrel shifter (SRL/SRA/ROR/SLL/ASL/ROL).
// $clog2(D_SIZE) mux layers spread over PIPE_STAGES register stages.
//
// Handshake: a transfer happens on a rising clk_in edge where valid and ready
// are both high. The producer holds its payload stable while valid is high and
// ready is low. ready_out = !valid_0 || advance_1, so bubbles collapse and a
// full pipeline accepts in the same cycle the output is taken.
module barrelshifter_pipe
    import barrelshifter_pkg::*;
#(
    parameter int D_SIZE      = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      valid_in,
    output logic                      ready_out,
    input  logic [D_SIZE-1:0]         x_in,
    input  logic [$clog2(D_SIZE)-1:0] s_in,
    input  logic [2:0]                op_in,
    output logic                      valid_out,
    input  logic                      ready_in,
    output logic [D_SIZE-1:0]         y_out,
    output logic                      zf_out,
    output logic                      vf_out
);

    localparam int NL   = $clog2(D_SIZE);
    localparam int LAST = PIPE_STAGES - 1;

    op_e               entry_op;
    logic [D_SIZE-1:0] x_rev;
    logic [D_SIZE-1:0] x_entry;
    logic              entry_vf;
    stage_t            entry_ctl;

    assign entry_op = decode_op(op_in);

    for (genvar i = 0; i < D_SIZE; i++) begin : g_x_rev
        assign x_rev[i] = x_in[D_SIZE-1-i];
    end

    assign x_entry = is_left(entry_op) ? x_rev : x_in;

    // ASL overflow: any bit shifted out from under the MSB differs from it
    always_comb begin
        entry_vf = 1'b0;
        if (entry_op == OP_ASL) begin
            for (int i = 0; i < D_SIZE - 1; i++) begin
                if ((i >= D_SIZE - 1 - int'(s_in)) && (x_in[i] != x_in[D_SIZE-1])) begin
                    entry_vf = 1'b1;
                end
            end
        end
    end

    assign entry_ctl = '{valid: valid_in, op: entry_op, shamt: SHAMT_W'(s_in), vf: entry_vf};

    for (genvar j = 0; j < PIPE_STAGES; j++) begin : g_stage
        localparam int LO = first_layer(NL, PIPE_STAGES, j);
        localparam int N  = layers_in_stage(NL, PIPE_STAGES, j);

        stage_t            src_ctl;
        logic [D_SIZE-1:0] src_data;
        logic [D_SIZE-1:0] chain [N+1];
        logic [D_SIZE-1:0] data_d;
        stage_t            ctl_q;
        logic [D_SIZE-1:0] data_q;
        logic              load;
        logic              adv_out;
        logic              unused_ctl;

        if (j == 0) begin : g_src_entry
            assign src_ctl  = entry_ctl;
            assign src_data = x_entry;
        end else begin : g_src_prev
            assign src_ctl  = g_stage[j-1].ctl_q;
            assign src_data = g_stage[j-1].data_q;
        end

        assign chain[0] = src_data;

        for (genvar m = 0; m < N; m++) begin : g_layer
            shift_layer #(
                .D_SIZE (D_SIZE),
                .K      (LO + m)
            ) u_layer (
                .data_i (chain[m]),
                .op_i   (src_ctl.op),
                .en_i   (src_ctl.shamt[LO+m]),
                .data_o (chain[m+1])
            );
        end

        if (j == LAST) begin : g_exit
            logic [D_SIZE-1:0] y_rev;
            logic [D_SIZE-1:0] y_fin;
            logic              zf_q;

            for (genvar i = 0; i < D_SIZE; i++) begin : g_y_rev
                assign y_rev[i] = chain[N][D_SIZE-1-i];
            end

            assign y_fin   = is_left(src_ctl.op) ? y_rev : chain[N];
            assign data_d  = y_fin;
            assign adv_out = ready_in;

            // Zero flag registered together with the final result
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    zf_q <= 1'b0;
                end else if (load && src_ctl.valid) begin
                    zf_q <= (y_fin == '0);
                end
            end
        end else begin : g_mid
            assign data_d  = chain[N];
            assign adv_out = g_stage[j+1].load;
        end

        assign load       = !ctl_q.valid || adv_out;
        assign unused_ctl = ^{ctl_q.op, ctl_q.shamt};

        // Stage register: loads when empty or when its contents move on
        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                ctl_q  <= '0;
                data_q <= '0;
            end else if (load) begin
                if (src_ctl.valid) begin
                    ctl_q  <= src_ctl;
                    data_q <= data_d;
                end else begin
                    ctl_q.valid <= 1'b0;
                end
            end
        end
    end

    assign ready_out = g_stage[0].load;
    assign valid_out = g_stage[LAST].ctl_q.valid;
    assign y_out     = g_stage[LAST].data_q;
    assign vf_out    = g_stage[LAST].ctl_q.vf;
    assign zf_out    = g_stage[LAST].g_exit.zf_q;

endmodule
